// File: rtl/gate_truth_table_sequencer_pkg.sv
// Shared types and constants for the gate truth-table sequencer:
// FSM state encoding and the gate-function codes carried on op.
package gate_tb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

endpackage

// File: rtl/gate_truth_table_sequencer_if.sv
// Bundle between the sequencer and its environment: sweep control,
// stimulus to the gate under test, and sweep results.
interface gate_truth_table_sequencer_if;

    logic       start;
    logic [1:0] op;
    logic       in0;
    logic       in1;
    logic       o;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;

    // The environment requests sweeps and closes the loop through the gate.
    modport master (
        output start, op, o,
        input  in0, in1, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        input  start, op, o,
        output in0, in1, busy, done, pass, err_count, fail_vec
    );

endinterface

// File: rtl/gate_truth_table_sequencer_ref_model.sv
// Combinational golden model: the value a correct gate of function op
// produces for inputs {in1,in0}.
module gate_ref_model
    import gate_tb_pkg::*;
(
    input  logic [1:0] op,
    input  logic       in0,
    input  logic       in1,
    output logic       exp
);

    always_comb begin
        exp = 1'b0;
        case (op)
            OP_AND:  exp = in0 & in1;
            OP_OR:   exp = in0 | in1;
            OP_XOR:  exp = in0 ^ in1;
            OP_NAND: exp = ~(in0 & in1);
            default: exp = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_truth_table_sequencer.sv
// Drives all four 2-input vectors into a gate under test, holding each for
// HOLD_CYCLES cycles, and checks the gate output against the latched function.
module gate_truth_table_sequencer
    import gate_tb_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 100
)
(
    input  logic                          clk,
    input  logic                          rst_n,
    gate_truth_table_sequencer_if.slave   bus
);

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    state_t      r_state;
    logic [1:0]  r_op;
    logic [1:0]  r_idx;
    logic [15:0] r_hold;
    logic        r_in0;
    logic        r_in1;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [2:0]  r_err_count;
    logic [3:0]  r_fail_vec;

    logic        w_exp;
    logic        w_sample;
    logic        w_mismatch;

    gate_ref_model u_ref (
        .op  (r_op),
        .in0 (r_in0),
        .in1 (r_in1),
        .exp (w_exp)
    );

    // The gate output is judged only on the last cycle of each hold window,
    // giving the gate the whole window to settle.
    assign w_sample   = (r_hold == HOLD_LAST);
    assign w_mismatch = (bus.o != w_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= 2'b00;
            r_idx       <= 2'b00;
            r_hold      <= 16'd0;
            r_in0       <= 1'b0;
            r_in1       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= 3'd0;
            r_fail_vec  <= 4'b0000;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_op        <= bus.op;
                        r_err_count <= 3'd0;
                        r_fail_vec  <= 4'b0000;
                        r_pass      <= 1'b0;
                        r_idx       <= 2'b00;
                        r_hold      <= 16'd0;
                        r_in0       <= 1'b0;
                        r_in1       <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    r_hold <= r_hold + 16'd1;
                    if (w_sample) begin
                        if (w_mismatch) begin
                            r_fail_vec[r_idx] <= 1'b1;
                            r_err_count       <= r_err_count + 3'd1;
                        end
                        if (r_idx != 2'd3) begin
                            r_idx          <= r_idx + 2'd1;
                            r_hold         <= 16'd0;
                            {r_in1, r_in0} <= r_idx + 2'd1;
                        end else begin
                            // Final vector: pass must include this last comparison.
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_in0   <= 1'b0;
                            r_in1   <= 1'b0;
                            r_pass  <= (r_err_count == 3'd0) && !w_mismatch;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in0       = r_in0;
    assign bus.in1       = r_in1;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err_count;
    assign bus.fail_vec  = r_fail_vec;

endmodule
